// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator datapath.
// Holds the ALU opcode enum and the controller state enum.
package calc_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    XOR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_LOAD2 = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/calc_rf.sv
// Register file: NREG x WIDTH, one write port, two async read ports.
// Ports: clk, rst (async high), i_we/i_waddr/i_wdata, i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b.
module calc_rf #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_waddr,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic [$clog2(NREG)-1:0] i_raddr_a,
  output logic [WIDTH-1:0]        o_rdata_a,
  input  logic [$clog2(NREG)-1:0] i_raddr_b,
  output logic [WIDTH-1:0]        o_rdata_b
);

  logic [WIDTH-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/calc_seq_dp.sv
// Sequential calculator: operands go through a register file, ALU result to R[NREG-1].
// Ports: clk, rst, start, chain, op, in1, in2 -> busy, done, out, ovf.
// Macro CALC_OVF_EN enables signed-overflow reporting on ovf (tied 0 otherwise).
module calc_seq_dp
  import calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             chain,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] R1   = AW'(1);

  state_e           r_state;
  op_e              r_op;
  logic             r_chain;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic [WIDTH-1:0] r_out;
  logic             r_done;

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [AW-1:0]    w_raddr_a;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res;

  // Port A serves operand A in EXEC and the stored result in DONE.
  assign w_raddr_a = (r_state == ST_EXEC && !r_chain) ? '0 : LAST;

  calc_rf #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_raddr_a),
    .o_rdata_a (w_a),
    .i_raddr_b (R1),
    .o_rdata_b (w_b)
  );

  always_comb begin
    w_res = '0;
    unique case (r_op)
      ADD: w_res = w_a + w_b;
      SUB: w_res = w_a - w_b;
      AND: w_res = w_a & w_b;
      XOR: w_res = w_a ^ w_b;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    unique case (r_state)
      ST_LOAD1: begin
        w_we    = 1'b1;
        w_waddr = '0;
        w_wdata = r_in1;
      end
      ST_LOAD2: begin
        w_we    = 1'b1;
        w_waddr = R1;
        w_wdata = r_in2;
      end
      ST_EXEC: begin
        w_we    = 1'b1;
        w_waddr = LAST;
        w_wdata = w_res;
      end
      default: ;
    endcase
  end

`ifdef CALC_OVF_EN
  logic w_ovf;
  logic r_ovf_pend;
  logic r_ovf;

  // Subtraction overflows when operand signs differ and the result
  // sign departs from A.
  always_comb begin
    w_ovf = 1'b0;
    unique case (r_op)
      ADD: w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                   (w_res[WIDTH-1] != w_a[WIDTH-1]);
      SUB: w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                   (w_res[WIDTH-1] != w_a[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_ovf_pend <= w_ovf;
    end else if (r_state == ST_DONE) begin
      r_ovf      <= r_ovf_pend;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= ADD;
      r_chain <= 1'b0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // The done-pulse cycle still counts as busy.
          if (start && !r_done) begin
            r_op    <= op_e'(op);
            r_chain <= chain;
            r_in1   <= in1;
            r_in2   <= in2;
            r_state <= chain ? ST_LOAD2 : ST_LOAD1;
          end
        end
        ST_LOAD1: r_state <= ST_LOAD2;
        ST_LOAD2: r_state <= ST_EXEC;
        ST_EXEC:  r_state <= ST_DONE;
        ST_DONE: begin
          r_out   <= w_a;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE) || r_done;
  assign done = r_done;
  assign out  = r_out;

endmodule

// File: tb/tb_calc_seq_dp.sv
// Scoreboard bench for calc_seq_dp: WIDTH=4/NREG=4 and WIDTH=8/NREG=8 instances.
// Stimulus pushes expected results; per-instance monitors pop on done.
module tb_calc_seq_dp;
  import calc_pkg::*;

`ifdef CALC_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  typedef struct {
    logic [7:0] out;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       st4 = 0, ch4 = 0, busy4, done4, ovf4;
  logic [1:0] op4 = 0;
  logic [3:0] a4 = 0, b4 = 0, out4;
  logic       st8 = 0, ch8 = 0, busy8, done8, ovf8;
  logic [1:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, out8;

  exp_t q4[$];
  exp_t q8[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_seq_dp #(.WIDTH(4), .NREG(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .chain(ch4), .op(op4),
    .in1(a4), .in2(b4), .busy(busy4), .done(done4), .out(out4), .ovf(ovf4)
  );

  calc_seq_dp #(.WIDTH(8), .NREG(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .chain(ch8), .op(op8),
    .in1(a8), .in2(b8), .busy(busy8), .done(done8), .out(out8), .ovf(ovf8)
  );

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        chk("w4 unexpected done", 1, 0);
      end else begin
        e = q4.pop_front();
        chk("w4 out", int'(out4), int'(e.out[3:0]));
        chk("w4 ovf", int'(ovf4), int'(e.ovf));
        chk("w4 done cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        chk("w8 unexpected done", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("w8 out", int'(out8), int'(e.out));
        chk("w8 ovf", int'(ovf8), int'(e.ovf));
        chk("w8 done cycle", cyc, e.due);
      end
    end
  end

  task automatic drv4(input logic s, input op_e o, input logic [3:0] a,
                      input logic [3:0] b, input logic c);
    st4 = s; op4 = o; a4 = a; b4 = b; ch4 = c;
  endtask

  task automatic run(input bit w8, input op_e o, input logic [7:0] a,
                     input logic [7:0] b, input bit c,
                     input logic [7:0] eo, input bit ev);
    int   lat;
    int   nb;
    exp_t e;
    lat = c ? 3 : 4;
    @(negedge clk);
    e.out = eo;
    e.ovf = ev;
    e.due = cyc + 1 + lat;
    if (w8) begin
      st8 = 1; op8 = o; a8 = a; b8 = b; ch8 = c;
      q8.push_back(e);
    end else begin
      drv4(1'b1, o, a[3:0], b[3:0], c);
      q4.push_back(e);
    end
    @(negedge clk);
    st4 = 0;
    st8 = 0;
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      if (!(w8 ? busy8 : busy4)) break;
      nb++;
      @(negedge clk);
    end
    chk(w8 ? "w8 busy cycles" : "w4 busy cycles", nb, lat + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst out", int'(out4), 0);
    chk("rst ovf", int'(ovf4), 0);
    chk("rst busy", int'(busy4), 0);
    chk("rst done", int'(done4), 0);
    rst = 0;
    @(negedge clk);

    run(0, ADD, 8'h0, 8'h5, 1, 8'h5, 0);
    run(0, ADD, 8'h3, 8'h4, 0, 8'h7, 0);
    run(0, SUB, 8'h2, 8'h5, 0, 8'hD, 0);
    run(0, ADD, 8'h7, 8'h1, 0, 8'h8, OVF);
    run(0, AND, 8'hC, 8'hA, 0, 8'h8, 0);
    run(0, XOR, 8'h0, 8'hF, 1, 8'h7, 0);
    run(0, SUB, 8'h8, 8'h1, 0, 8'h7, OVF);
    run(0, XOR, 8'h6, 8'h3, 0, 8'h5, 0);

    begin
      exp_t e;
      @(negedge clk);
      drv4(1, ADD, 4'h1, 4'h2, 0);
      e.out = 8'h3; e.ovf = 0; e.due = cyc + 5;
      q4.push_back(e);
      @(negedge clk); drv4(0, ADD, 0, 0, 0);
      @(negedge clk); drv4(1, SUB, 4'h5, 4'h6, 0);
      @(negedge clk); drv4(0, ADD, 0, 0, 0);
      @(negedge clk); drv4(1, XOR, 4'h9, 4'h9, 0);
      @(negedge clk);
      @(negedge clk); drv4(0, ADD, 0, 0, 0);
      repeat (6) @(negedge clk);
      chk("ignored start out", int'(out4), 3);
      chk("ignored start idle", int'(busy4), 0);
    end

    @(negedge clk); drv4(1, ADD, 4'h5, 4'h5, 0);
    @(negedge clk); drv4(0, ADD, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort out", int'(out4), 0);
    chk("abort busy", int'(busy4), 0);
    chk("abort done", int'(done4), 0);
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    run(0, ADD, 8'h1, 8'h1, 0, 8'h2, 0);

    run(1, ADD, 8'hFF, 8'h01, 0, 8'h00, 0);
    run(1, SUB, 8'h80, 8'h01, 0, 8'h7F, OVF);

    repeat (5) @(negedge clk);
    chk("w4 pending results", q4.size(), 0);
    chk("w8 pending results", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
